// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one test-memory port between host and engine
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_wdata,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [DATA_WIDTH-1:0] e_rdata,
    input  logic                  excl,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PD = RD_LATENCY + 1;

    logic          ptr_e;
    logic          h_req_m;
    logic          gnt_h;
    logic          gnt_e;
    logic          issue_rd;
    logic [PD-1:0] pipe_v;
    logic [PD-1:0] pipe_id;

    // Host is masked before arbitration so exclusive mode never moves the pointer.
    always_comb begin
        h_req_m  = h_req & ~excl;
        gnt_h    = ~rst & h_req_m & (~e_req | ~ptr_e);
        gnt_e    = ~rst & e_req & (~h_req_m | ptr_e);
        issue_rd = (gnt_h & ~h_we) | (gnt_e & ~e_we);
    end

    assign h_gnt = gnt_h;
    assign e_gnt = gnt_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_e <= 1'b0;
        end else if (gnt_h) begin
            ptr_e <= 1'b1;
        end else if (gnt_e) begin
            ptr_e <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= gnt_h | gnt_e;
            mem_we <= (gnt_h & h_we) | (gnt_e & e_we);
            if (gnt_h) begin
                mem_addr  <= h_addr;
                mem_wdata <= h_wdata;
            end else if (gnt_e) begin
                mem_addr  <= e_addr;
                mem_wdata <= e_wdata;
            end
        end
    end

    // Stage RD_LATENCY lines up with the cycle in which mem_rdata is valid for that read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v   <= '0;
            pipe_id  <= '0;
            h_rvalid <= 1'b0;
            e_rvalid <= 1'b0;
            h_rdata  <= '0;
            e_rdata  <= '0;
        end else begin
            pipe_v   <= {pipe_v[PD-2:0], issue_rd};
            pipe_id  <= {pipe_id[PD-2:0], gnt_e};
            h_rvalid <= pipe_v[RD_LATENCY] & ~pipe_id[RD_LATENCY];
            e_rvalid <= pipe_v[RD_LATENCY] & pipe_id[RD_LATENCY];
            if (pipe_v[RD_LATENCY] && !pipe_id[RD_LATENCY]) begin
                h_rdata <= mem_rdata;
            end
            if (pipe_v[RD_LATENCY] && pipe_id[RD_LATENCY]) begin
                e_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at read latency 1 and 4
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_req = 1'b0, h_we = 1'b0, e_req = 1'b0, e_we = 1'b0, excl = 1'b0;
    logic [31:0] h_addr = '0, h_wdata = '0, e_addr = '0, e_wdata = '0;

    logic        a_h_gnt, a_h_rvalid, a_e_gnt, a_e_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_h_rdata, a_e_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_h_gnt, b_h_rvalid, b_e_gnt, b_e_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_h_rdata, b_e_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(a_h_gnt), .h_rvalid(a_h_rvalid), .h_rdata(a_h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(a_e_gnt), .e_rvalid(a_e_rvalid), .e_rdata(a_e_rdata),
        .excl(excl),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(4)) dut_b (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(b_h_gnt), .h_rvalid(b_h_rvalid), .h_rdata(b_h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(b_e_gnt), .e_rvalid(b_e_rvalid), .e_rdata(b_e_rdata),
        .excl(excl),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hA000_0000 | {24'h0, a[7:0]});
    endfunction

    logic [31:0] ma_arr [256];
    logic        ma_wr  [256];
    logic [31:0] mb_arr [256];
    logic        mb_wr  [256];
    logic [31:0] mb_d1, mb_d2, mb_d3;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ma_wr[i] <= 1'b0;
        end else if (a_mem_en && a_mem_we) begin
            ma_arr[a_mem_addr[7:0]] <= a_mem_wdata;
            ma_wr[a_mem_addr[7:0]]  <= 1'b1;
        end
        a_mem_rdata <= ma_wr[a_mem_addr[7:0]] ? ma_arr[a_mem_addr[7:0]] : dflt(a_mem_addr);
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mb_wr[i] <= 1'b0;
        end else if (b_mem_en && b_mem_we) begin
            mb_arr[b_mem_addr[7:0]] <= b_mem_wdata;
            mb_wr[b_mem_addr[7:0]]  <= 1'b1;
        end
        mb_d1       <= mb_wr[b_mem_addr[7:0]] ? mb_arr[b_mem_addr[7:0]] : dflt(b_mem_addr);
        mb_d2       <= mb_d1;
        mb_d3       <= mb_d2;
        b_mem_rdata <= mb_d3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        h_req = 1'b0; e_req = 1'b0; excl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic excl;
        logic h;
        logic e;
        logic xh;
        logic xe;
    } vec_t;

    vec_t tbl [12];
    logic prev_h, prev_e;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // reset values while rst is held
        @(negedge clk);
        #1;
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_h_rvalid", a_h_rvalid, 0);
        chk("rst_e_rdata", a_e_rdata, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        do_reset();

        // table: arbitration and pointer sequence, writes only
        h_we = 1'b1; e_we = 1'b1;
        h_addr = 32'h40; e_addr = 32'h80;
        h_wdata = 32'h1111_0000; e_wdata = 32'h2222_0000;
        prev_h = 1'b0; prev_e = 1'b0;
        for (int i = 0; i < 12; i++) begin
            excl = tbl[i].excl; h_req = tbl[i].h; e_req = tbl[i].e;
            #1;
            chk($sformatf("tbl%0d_mem_en", i), a_mem_en, prev_h | prev_e);
            if (prev_h) chk($sformatf("tbl%0d_addr_h", i), a_mem_addr, 32'h40);
            if (prev_e) chk($sformatf("tbl%0d_addr_e", i), a_mem_addr, 32'h80);
            chk($sformatf("tbl%0d_h_gnt", i), a_h_gnt, tbl[i].xh);
            chk($sformatf("tbl%0d_e_gnt", i), a_e_gnt, tbl[i].xe);
            prev_h = tbl[i].xh; prev_e = tbl[i].xe;
            @(negedge clk);
        end
        h_req = 1'b0; e_req = 1'b0; excl = 1'b0;
        #1;
        chk("tbl_end_mem_en", a_mem_en, 1);
        chk("tbl_end_mem_we", a_mem_we, 1);

        // 1: lone host read
        do_reset();
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h10;
        #1; chk("t1_h_gnt", a_h_gnt, 1); chk("t1_e_gnt", a_e_gnt, 0);
        @(negedge clk); h_req = 1'b0;
        #1; chk("t1_mem_en", a_mem_en, 1); chk("t1_mem_we", a_mem_we, 0); chk("t1_mem_addr", a_mem_addr, 32'h10);
        @(negedge clk);
        #1; chk("t1_h_rvalid_t2", a_h_rvalid, 0); chk("t1_mem_en_t2", a_mem_en, 0);
        @(negedge clk);
        #1; chk("t1_h_rvalid_t3", a_h_rvalid, 1); chk("t1_h_rdata", a_h_rdata, 32'hDEAD_BEEF);
        chk("t1_e_rvalid", a_e_rvalid, 0);
        @(negedge clk);
        #1; chk("t1_h_rvalid_t4", a_h_rvalid, 0);

        // 2: continuous contention, alternating grants and routed returns
        do_reset();
        h_we = 1'b0; e_we = 1'b0; h_addr = 32'h11; e_addr = 32'h21;
        for (int c = 0; c < 10; c++) begin
            h_req = (c < 6); e_req = (c < 6);
            #1;
            if (c < 6) begin
                chk($sformatf("t2_h_gnt%0d", c), a_h_gnt, (c % 2 == 0));
                chk($sformatf("t2_e_gnt%0d", c), a_e_gnt, (c % 2 == 1));
            end
            chk($sformatf("t2_h_rvalid%0d", c), a_h_rvalid, (c == 3 || c == 5 || c == 7));
            chk($sformatf("t2_e_rvalid%0d", c), a_e_rvalid, (c == 4 || c == 6 || c == 8));
            if (c == 3 || c == 5 || c == 7) chk($sformatf("t2_h_rdata%0d", c), a_h_rdata, 32'hA000_0011);
            if (c == 4 || c == 6 || c == 8) chk($sformatf("t2_e_rdata%0d", c), a_e_rdata, 32'hA000_0021);
            @(negedge clk);
        end

        // 3: exclusive mode masks host without advancing pointer
        do_reset();
        excl = 1'b1; h_req = 1'b1; e_req = 1'b1; h_we = 1'b1; e_we = 1'b1;
        h_addr = 32'h50; e_addr = 32'h60;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t3_h_gnt%0d", c), a_h_gnt, 0);
            chk($sformatf("t3_e_gnt%0d", c), a_e_gnt, 1);
            @(negedge clk);
        end
        excl = 1'b0;
        #1; chk("t3_h_gnt_after", a_h_gnt, 1); chk("t3_e_gnt_after", a_e_gnt, 0);
        @(negedge clk); h_req = 1'b0; e_req = 1'b0;

        // 4: host write then engine read of the same address
        do_reset();
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h20; h_wdata = 32'h1234_5678;
        #1; chk("t4_h_gnt", a_h_gnt, 1);
        @(negedge clk);
        h_req = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h20;
        #1; chk("t4_e_gnt", a_e_gnt, 1); chk("t4_mem_we1", a_mem_we, 1);
        chk("t4_mem_addr", a_mem_addr, 32'h20); chk("t4_mem_wdata", a_mem_wdata, 32'h1234_5678);
        @(negedge clk); e_req = 1'b0;
        #1; chk("t4_mem_en2", a_mem_en, 1); chk("t4_mem_we2", a_mem_we, 0);
        @(negedge clk);
        #1; chk("t4_e_rvalid_early", a_e_rvalid, 0);
        @(negedge clk);
        #1; chk("t4_e_rvalid", a_e_rvalid, 1); chk("t4_e_rdata", a_e_rdata, 32'h1234_5678);
        chk("t4_h_rvalid", a_h_rvalid, 0);

        // 5: reset while reads are in flight
        do_reset();
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h30;
        @(negedge clk);
        h_req = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h31;
        @(negedge clk);
        e_req = 1'b0; h_req = 1'b1; rst = 1'b1;
        #1;
        chk("t5_rst_h_gnt", a_h_gnt, 0); chk("t5_rst_mem_en", a_mem_en, 0);
        chk("t5_rst_h_rdata", a_h_rdata, 0); chk("t5_rst_e_rdata", a_e_rdata, 0);
        chk("t5_rst_mem_addr", a_mem_addr, 0);
        @(negedge clk);
        rst = 1'b0; h_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("t5_h_rvalid%0d", c), a_h_rvalid, 0);
            chk($sformatf("t5_e_rvalid%0d", c), a_e_rvalid, 0);
            @(negedge clk);
        end
        h_req = 1'b1; e_req = 1'b1;
        #1; chk("t5_ptr_h", a_h_gnt, 1); chk("t5_ptr_e", a_e_gnt, 0);
        @(negedge clk); h_req = 1'b0; e_req = 1'b0;

        // 6: latency-4 instance, back-to-back engine reads
        do_reset();
        e_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            e_req = (c < 4); e_addr = c;
            #1;
            if (c < 4) chk($sformatf("t6_e_gnt%0d", c), b_e_gnt, 1);
            chk($sformatf("t6_e_rvalid%0d", c), b_e_rvalid, (c >= 6 && c <= 9));
            if (c >= 6 && c <= 9) chk($sformatf("t6_e_rdata%0d", c), b_e_rdata, 32'hA000_0000 | (c - 6));
            chk($sformatf("t6_h_rvalid%0d", c), b_h_rvalid, 0);
            if (c == 1) begin
                chk("t6_h_gnt", b_h_gnt, 0);
                chk("t6_mem_we", b_mem_we, 0);
                chk("t6_mem_en", b_mem_en, 1);
                chk("t6_h_rdata", b_h_rdata, 0);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single test-memory port between two requesters: the UART host command path (port H) and the GA test engine (port E).
- Round-robin arbitration with a per-cycle request/grant handshake. Memory command outputs are registered.
- Read data is tagged and returned only to the requester that issued the read, so multiple reads can be in flight at once.
- An exclusive-mode input lets the test engine own the port while a test runs.

Parameters:
ADDR_WIDTH, 32, address width of both requesters and the memory
DATA_WIDTH, 32, data width of both requesters and the memory
RD_LATENCY, 1, cycles from registered mem_en to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
h_req  in  1  host request; held with fields stable until h_gnt
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_WIDTH  host address
h_wdata  in  DATA_WIDTH  host write data
h_gnt  out  1  host request accepted this cycle (combinational)
h_rvalid  out  1  host read data valid (1-cycle pulse)
h_rdata  out  DATA_WIDTH  host read data
e_req, e_we, e_addr, e_wdata, e_gnt, e_rvalid, e_rdata  same as host, engine side
excl  in  1  engine-exclusive mode; host never granted while high
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, while rst high): all outputs 0. RR pointer favours H. Read-tracking pipe cleared.
- Arbitration, combinational in cycle t:
  - Only H requesting → grant H.
  - Only E requesting → grant E.
  - Both requesting → grant the port the pointer favours.
  - excl=1 → H is masked before arbitration, so only E can be granted.
  - At most one gnt per cycle. gnt is never asserted without the matching req.
- Pointer update: after any grant the pointer favours the other port. No grant → pointer unchanged. Masking H under excl does not update the pointer.
- Command issue:
  - On the edge ending a grant cycle t, register mem_en=1 plus mem_we/addr/wdata from the winner; these are visible in cycle t+1.
  - Cycles without a grant → mem_en=0 and mem_we=0; addr/wdata hold their last value.
- Throughput:
  - One access per cycle; back-to-back grants allowed.
  - Under continuous contention the grants strictly alternate H,E,H,E…
  - Worst-case wait for a requesting port is 1 cycle, except H while excl=1.
- Read tracking:
  - Shift register of depth RD_LATENCY+1 carrying {valid, id}, entered when a read command is registered.
  - mem_rdata is sampled in cycle t+1+RD_LATENCY.
  - The routed requester sees rvalid=1 and rdata in cycle t+2+RD_LATENCY; with RD_LATENCY=1 that is t+3.
  - The other port's rvalid stays 0. Its rdata holds its last value, never overwritten.
  - Writes produce no response; a write is complete at gnt.
- Ordering: accesses reach memory in grant order. A read granted after a write to the same address returns the new data, given the memory's read-after-write behaviour.
- Requester rules:
  - Dropping req before gnt is legal (request withdrawn).
  - Changing fields while req is high without gnt is a protocol violation and is not checked.
- excl toggles take effect the same cycle and do not disturb in-flight reads.
- Reset mid-operation: in-flight reads are discarded; no rvalid appears after rst deasserts.

Test Plan:
1. H read addr 0x10 alone, memory returns 0xDEADBEEF, RD_LATENCY=1 → h_gnt in cycle t; mem_en=1, we=0, addr=0x10 in t+1; h_rvalid=1, h_rdata=0xDEADBEEF in t+3; e_rvalid stays 0.
2. H and E request reads continuously from reset for 6 cycles → grants H,E,H,E,H,E; each rvalid pulse returns that port's own address data, in order.
3. excl=1, both requesting writes → only e_gnt for 4 cycles; excl drops → next grant goes to H, since the pointer was not advanced by masking.
4. H write 0x20 ← 0x12345678, then E read 0x20 on the next grant → mem_we=1 then mem_we=0, and e_rdata=0x12345678.
5. Reads issued to both ports, rst pulsed for 1 cycle before data returns → all outputs 0 during reset; no rvalid afterwards; pointer favours H.
6. RD_LATENCY=4, back-to-back E reads of 0x0..0x3 → four consecutive e_rvalid pulses 6 cycles after their grants, data in address order.
